// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock, signed or unsigned operands.
// Start/busy/done handshake; the product register holds its value until the next operation completes.
//
// state  | meaning
// IDLE   | waiting for start, busy=0, done=0
// RUN    | iterating Booth digits, busy=1
// DONE   | product valid, done=1 for one cycle; start here re-enters RUN directly
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH/2 + 2);
  localparam logic [CW-1:0] LAST_SIGNED   = CW'(WIDTH/2 - 1);
  localparam logic [CW-1:0] LAST_UNSIGNED = CW'(WIDTH/2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] m_reg;
  logic [AW-1:0] a_reg;
  logic [AW-1:0] q_reg;
  logic          q_m1;
  logic [CW-1:0] cnt;
  logic          mode_reg;

  logic          load;
  logic          last_iter;
  logic [CW-1:0] last_cnt;

  logic [2:0]    digit;
  logic [AW-1:0] mult;
  logic          neg;
  logic [AW-1:0] addend;
  logic [AW-1:0] a_sum;
  logic [2*AW:0] sh;
  logic [AW-1:0] a_shift;
  logic [AW-1:0] q_shift;
  logic          qm1_shift;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

  logic [AW-1:0] m_load;
  logic [AW-1:0] q_load;

  assign load      = start && (state != S_RUN);
  assign last_cnt  = mode_reg ? LAST_SIGNED : LAST_UNSIGNED;
  assign last_iter = (state == S_RUN) && (cnt == last_cnt);

  assign m_load = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  assign q_load = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = last_iter ? S_DONE : S_RUN;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Booth digit decode: selects 0, M or 2M and whether to subtract
  assign digit = {q_reg[1:0], q_m1};

  always_comb begin
    mult = '0;
    neg  = 1'b0;
    case (digit)
      3'b001, 3'b010: mult = m_reg;
      3'b011:         mult = {m_reg[AW-2:0], 1'b0};
      3'b100: begin
        mult = {m_reg[AW-2:0], 1'b0};
        neg  = 1'b1;
      end
      3'b101, 3'b110: begin
        mult = m_reg;
        neg  = 1'b1;
      end
      default: begin
        mult = '0;
        neg  = 1'b0;
      end
    endcase
  end

  assign addend = neg ? ~mult : mult;
  assign a_sum  = a_reg + addend + {{(AW-1){1'b0}}, neg};

  assign sh        = {{2{a_sum[AW-1]}}, a_sum[AW-1:1], a_sum[0], q_reg, q_m1} >> 2;
  assign a_shift   = sh[2*AW:AW+1];
  assign q_shift   = sh[AW:1];
  assign qm1_shift = sh[0];

  // Signed runs shift only WIDTH bits, so two stale multiplier bits remain at the bottom of Q
  assign prod_s = {a_shift[WIDTH-1:0], q_shift[AW-1:2]};
  assign prod_u = {a_shift[WIDTH-3:0], q_shift};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_reg    <= '0;
      a_reg    <= '0;
      q_reg    <= '0;
      q_m1     <= 1'b0;
      cnt      <= '0;
      mode_reg <= 1'b0;
      product  <= '0;
    end else if (load) begin
      m_reg    <= m_load;
      a_reg    <= '0;
      q_reg    <= q_load;
      q_m1     <= 1'b0;
      cnt      <= '0;
      mode_reg <= signed_mode;
    end else if (state == S_RUN) begin
      a_reg <= a_shift;
      q_reg <= q_shift;
      q_m1  <= qm1_shift;
      cnt   <= cnt + 1'b1;
      if (last_iter) begin
        product <= mode_reg ? prod_s : prod_u;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised checks of booth_mult_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;

  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic        start8 = 1'b0;
  logic        mode8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic [7:0]  y8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .signed_mode(signed_mode),
    .x(x), .y(y), .busy(busy), .done(done), .product(product)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(mode8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .product(product8)
  );

  // Waits (bounded) for done on the 32-bit unit, checking busy/done each cycle; lat counts edges after acceptance
  task automatic wait_done32(inout int lat);
    while (done !== 1'b1 && lat < 40) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_during_run32: busy=%b required 1 at lat %0d", busy, lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout32: done=%b required 1 after %0d cycles", done, lat);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_with_done32: busy=%b required 0", busy);
    end
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic m,
                      output logic [63:0] p, output int lat);
    @(posedge clk); #1;
    start = 1'b1; x = a; y = b; signed_mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    wait_done32(lat);
    p = product;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                     output logic [15:0] p, output int lat);
    @(posedge clk); #1;
    start8 = 1'b1; x8 = a; y8 = b; mode8 = m;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      n_checks++;
      if (busy8 !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_during_run8: busy=%b required 1 at lat %0d", busy8, lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_state8: done=%b busy=%b required done=1 busy=0", done8, busy8);
    end
    p = product8;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
    end
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state8: busy=%b done=%b product=%h required 0/0/0", busy8, done8, product8);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  task automatic test_signed_basic();
    logic [63:0] p;
    int lat;
    op32(32'd172, 32'd172, 1'b1, p, lat);
    n_checks++;
    if (p !== 64'h7390) begin
      n_fail++;
      $display("FAIL signed_172sq: product=%h required 7390", p);
    end
    n_checks++;
    if (lat != 16) begin
      n_fail++;
      $display("FAIL signed_latency: latency=%0d required 16", lat);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b busy=%b required 0/0", done, busy);
    end
    n_checks++;
    if (product !== 64'h7390) begin
      n_fail++;
      $display("FAIL product_hold: product=%h required 7390", product);
    end
  endtask

  task automatic test_signed_extremes();
    logic [63:0] p;
    int lat;
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, p, lat);
    n_checks++;
    if (p !== 64'h4000_0000_0000_0000) begin
      n_fail++;
      $display("FAIL most_negative_sq: product=%h required 4000000000000000", p);
    end
    op32(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, p, lat);
    n_checks++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL minus1_times2: product=%h required fffffffffffffffe", p);
    end
    n_checks++;
    if (lat != 16) begin
      n_fail++;
      $display("FAIL signed_latency2: latency=%0d required 16", lat);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] p;
    int lat;
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat);
    n_checks++;
    if (p !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++;
      $display("FAIL unsigned_all_ones: product=%h required fffffffe00000001", p);
    end
    n_checks++;
    if (lat != 17) begin
      n_fail++;
      $display("FAIL unsigned_latency: latency=%0d required 17", lat);
    end
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, lat);
    n_checks++;
    if (p !== 64'h1) begin
      n_fail++;
      $display("FAIL signed_all_ones: product=%h required 1", p);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] old_p;
    @(posedge clk); #1;
    old_p = product;
    start = 1'b1; x = 32'd3; y = 32'd5; signed_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (product !== old_p) begin
      n_fail++;
      $display("FAIL product_during_run: product=%h required %h", product, old_p);
    end
    lat = 0;
    repeat (4) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b1; x = 32'd7; y = 32'd7;
    @(posedge clk); #1;
    lat++;
    start = 1'b0; x = '0; y = '0;
    wait_done32(lat);
    n_checks++;
    if (product !== 64'd15 || lat != 16) begin
      n_fail++;
      $display("FAIL start_during_run_ignored: product=%h latency=%0d required f/16", product, lat);
    end
    start = 1'b1; x = 32'hFFFF_FFFC; y = 32'd6; signed_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 64'd15) begin
      n_fail++;
      $display("FAIL back_to_back_entry: busy=%b done=%b product=%h required 1/0/f", busy, done, product);
    end
    lat = 0;
    wait_done32(lat);
    n_checks++;
    if (product !== 64'hFFFF_FFFF_FFFF_FFE8 || lat != 16) begin
      n_fail++;
      $display("FAIL back_to_back_result: product=%h latency=%0d required ffffffffffffffe8/16", product, lat);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_extra_done: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] p;
    int lat;
    @(posedge clk); #1;
    start = 1'b1; x = 32'd172; y = 32'd172; signed_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    op32(32'd9, 32'd9, 1'b1, p, lat);
    n_checks++;
    if (p !== 64'd81 || lat != 16) begin
      n_fail++;
      $display("FAIL after_reset_9x9: product=%h latency=%0d required 51/16", p, lat);
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, b;
    logic m;
    logic [63:0] p, exp_p;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      m = 1'($urandom_range(0, 1));
      if (i % 10 == 0) a = 32'h8000_0000;
      if (i % 10 == 5) b = 32'hFFFF_FFFF;
      exp_p = m ? ({{32{a[31]}}, a} * {{32{b[31]}}, b}) : ({32'd0, a} * {32'd0, b});
      exp_lat = m ? 16 : 17;
      op32(a, b, m, p, lat);
      n_checks++;
      if (p !== exp_p || lat != exp_lat) begin
        n_fail++;
        $display("FAIL random32 %h*%h mode=%b: product=%h latency=%0d required %h/%0d",
                 a, b, m, p, lat, exp_p, exp_lat);
      end
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b;
    logic m;
    logic [15:0] p, exp_p;
    int lat, exp_lat;
    for (int i = 0; i < 120; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      m = 1'($urandom_range(0, 1));
      if (i % 12 == 0) begin a = 8'h80; b = 8'h80; end
      if (i % 12 == 6) begin a = 8'hFF; b = 8'hFF; end
      exp_p = m ? ({{8{a[7]}}, a} * {{8{b[7]}}, b}) : ({8'd0, a} * {8'd0, b});
      exp_lat = m ? 4 : 5;
      op8(a, b, m, p, lat);
      n_checks++;
      if (p !== exp_p || lat != exp_lat) begin
        n_fail++;
        $display("FAIL random8 %h*%h mode=%b: product=%h latency=%0d required %h/%0d",
                 a, b, m, p, lat, exp_p, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_signed_extremes();
    test_unsigned();
    test_back_to_back();
    test_reset_mid_op();
    test_random32();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
